pll_reset_sequencer: RTL and testbench

//  Supervises the system clock PLL (50 MHz ref -> 100 MHz) and generates the design reset.

---
 rtl/pll_reset_sequencer.sv | 144 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Supervises the system-clock PLL and produces the design reset request.
// Runs on the free-running reference clock, so it keeps operating while the
// PLL is unlocked. The PLL is held in reset for a fixed time, then the
// sequencer waits for lock (retrying on timeout), requires lock to stay
// stable, holds sys_rst for a further period and finally releases it. Any
// loss of lock sends it back to waiting for lock with sys_rst asserted.
//
// Ports
//   clk           in   reference clock (same net as the PLL refclk)
//   rst           in   synchronous, active-high reset
//   pll_locked    in   PLL lock indicator, asynchronous to clk
//   pll_rst       out  reset to the PLL
//   sys_rst       out  design reset request, active high (level)
//   ready         out  high only in RUN
//   state_o       out  current state encoding (debug)
//   retry_count   out  lock-timeout retries since rst, saturating
//   relock_count  out  RUN -> lock-loss events since rst, saturating
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT       = 100000,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 64,
    parameter int CNT_W              = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retry_count,
    output logic [CNT_W-1:0] relock_count
);

    // The shared dwell counter must reach the largest terminal count.
    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX_B = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                               LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int TW        = $clog2(CNT_MAX + 1);

    localparam logic [TW-1:0] PR_LAST = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] ST_LAST = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0] HD_LAST = TW'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_HOLD      = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] retry_q, retry_d;
    logic [CNT_W-1:0] relock_q, relock_d;
    logic             sync1_q, lk_q;
    logic             pll_rst_q, sys_rst_q, ready_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Next-state logic. Lock loss always takes priority over a terminal
    // count; in WAIT_LOCK, seeing lock takes priority over the timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        retry_d  = retry_q;
        relock_d = relock_q;
        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == PR_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lk_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_PLL_RST;
                    retry_d = sat_inc(retry_q);
                end
            end
            S_STABLE: begin
                if (!lk_q)                  state_d = S_WAIT_LOCK;
                else if (cnt_q == ST_LAST)  state_d = S_HOLD;
            end
            S_HOLD: begin
                if (!lk_q)                  state_d = S_WAIT_LOCK;
                else if (cnt_q == HD_LAST)  state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q;  // no timing in RUN; keep the counter parked
                if (!lk_q) begin
                    state_d  = S_WAIT_LOCK;
                    relock_d = sat_inc(relock_q);
                end
            end
            default: state_d = S_PLL_RST;  // unused encodings recover
        endcase
        // Every state entry starts the dwell count from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    // Outputs are decoded from the next state and registered, so they move
    // in the same cycle as state_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_PLL_RST;
            cnt_q     <= '0;
            sync1_q   <= 1'b0;
            lk_q      <= 1'b0;
            retry_q   <= '0;
            relock_q  <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= pll_locked;
            lk_q      <= sync1_q;
            retry_q   <= retry_d;
            relock_q  <= relock_d;
            pll_rst_q <= (state_d == S_PLL_RST);
            sys_rst_q <= (state_d != S_RUN);
            ready_q   <= (state_d == S_RUN);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign sys_rst      = sys_rst_q;
    assign ready        = ready_q;
    assign state_o      = state_q;
    assign retry_count  = retry_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Drives reset and pll_locked once per cycle. A reference model built from
// dwell times and the lock history predicts the registered outputs for every
// cycle and queues them; a separate monitor pops and compares each cycle.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

    localparam int T_RST = 4;
    localparam int T_TO  = 20;
    localparam int T_ST  = 8;
    localparam int T_HD  = 6;
    localparam int CW    = 2;
    localparam int SAT   = (1 << CW) - 1;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_HOLD = 3;
    localparam int P_RUN  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          pll_rst, sys_rst, ready;
    logic [2:0]    state_o;
    logic [CW-1:0] retry_count, relock_count;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES    (T_RST),
        .LOCK_TIMEOUT      (T_TO),
        .LOCK_STABLE_CYCLES(T_ST),
        .RESET_HOLD_CYCLES (T_HD),
        .CNT_W             (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .state_o     (state_o),
        .retry_count (retry_count),
        .relock_count(relock_count)
    );

    always #5 clk = ~clk;

    // Reference model: phase, the time it was entered, and lock history.
    int   phase   = P_RST;
    int   t_now   = 0;
    int   t_enter = 1;
    int   retry   = 0;
    int   relock  = 0;
    bit   lhist[$];

    logic [9:0] exp_q[$];
    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic model_step(input logic r, input logic l);
        int dwell;
        int lk;
        int nxt;
        if (r) begin
            phase   = P_RST;
            t_enter = t_now + 1;
            retry   = 0;
            relock  = 0;
            lhist.delete();
        end else begin
            dwell = t_now - t_enter + 1;
            // lock seen by the decision logic is the input from two cycles back
            lk  = (lhist.size() >= 2) ? int'(lhist[lhist.size()-2]) : 0;
            nxt = phase;
            case (phase)
                P_RST:  if (dwell == T_RST) nxt = P_WAIT;
                P_WAIT: begin
                    if (lk != 0) nxt = P_STAB;
                    else if (dwell == T_TO) begin
                        nxt = P_RST;
                        if (retry < SAT) retry++;
                    end
                end
                P_STAB: if (lk == 0) nxt = P_WAIT; else if (dwell == T_ST) nxt = P_HOLD;
                P_HOLD: if (lk == 0) nxt = P_WAIT; else if (dwell == T_HD) nxt = P_RUN;
                default: if (lk == 0) begin
                    nxt = P_WAIT;
                    if (relock < SAT) relock++;
                end
            endcase
            if (nxt != phase) begin
                phase   = nxt;
                t_enter = t_now + 1;
            end
            lhist.push_back(l);
            if (lhist.size() > 4) void'(lhist.pop_front());
        end
        t_now++;
    endtask

    function automatic logic [9:0] expected();
        logic [2:0]    st;
        logic [CW-1:0] rc, lc;
        st = 3'(phase);
        rc = CW'(retry);
        lc = CW'(relock);
        return {phase == P_RST, phase != P_RUN, phase == P_RUN, st, rc, lc};
    endfunction

    function automatic int elapsed();
        return t_now - t_enter;
    endfunction

    task automatic cycle(input logic r, input logic l);
        @(negedge clk);
        rst        = r;
        pll_locked = l;
        model_step(r, l);
        exp_q.push_back(expected());
    endtask

    // Monitor: one expected vector per clock once stimulus has started.
    initial begin
        logic [9:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pll_rst, sys_rst, ready, state_o, retry_count, relock_count};
                vec_cnt++;
                if (a !== e) begin
                    miss_cnt++;
                    $display("FAIL outputs @%0t: got pll_rst=%b sys_rst=%b ready=%b state=%0d retry=%0d relock=%0d, want pll_rst=%b sys_rst=%b ready=%b state=%0d retry=%0d relock=%0d",
                             $time, a[9], a[8], a[7], a[6:4], a[3:2], a[1:0],
                             e[9], e[8], e[7], e[6:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        int len;
        logic lvl;
        // Reset, then lock held through to RUN.
        repeat (3) cycle(1'b1, 1'b0);
        for (int i = 0; i < 100 && phase != P_RUN; i++) cycle(1'b0, 1'b1);
        repeat (5) cycle(1'b0, 1'b1);

        // Lock loss in RUN, then relock back to RUN.
        repeat (5) cycle(1'b0, 1'b0);
        for (int i = 0; i < 100 && phase != P_RUN; i++) cycle(1'b0, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);

        // Reset while in RUN.
        cycle(1'b1, 1'b1);
        repeat (2) cycle(1'b0, 1'b0);

        // No lock at all: repeated retries until the count saturates.
        repeat (110) cycle(1'b0, 1'b0);

        // One-cycle glitch seen by the sequencer at count 5 of STABLE.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 100 && !(phase == P_STAB && elapsed() == 3); i++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 100 && phase != P_RUN; i++) cycle(1'b0, 1'b1);
        repeat (2) cycle(1'b0, 1'b1);

        // Lock arrives in the very cycle the WAIT_LOCK timeout expires.
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 100 && !(phase == P_WAIT && elapsed() == 17); i++) cycle(1'b0, 1'b0);
        repeat (6) cycle(1'b0, 1'b1);

        // Random segments of lock/unlock with occasional resets.
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(1, 30);
            lvl = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) cycle(1'b1, lvl);
            repeat (len) cycle(1'b0, lvl);
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            miss_cnt++;
            $display("FAIL drain: got %0d unchecked vectors, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
